g2e_buffer_ctrl: RTL and testbench

Single-clock sequencer for the 8-to-11-bit gearbox bit buffer in the Hamming encode path. It owns the bit-level write pointer, read pointer and occupancy of the circular bit buffer. It runs valid/ready handshakes toward the byte producer and the 11-bit encoder consumer, and drives the buffer datapath's write/read enables and bit offsets. A flush request drains any residue as one final zero-padded read word.

---
 rtl/g2e_buffer_ctrl.sv | 152 +++++++++++++++
 tb/tb_g2e_buffer_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/g2e_buffer_ctrl.sv
// g2e_buffer_ctrl
// Sequencer for the 8-to-11-bit gearbox bit buffer used in the Hamming encode
// path. It owns the write pointer, read pointer and occupancy (all in bits) of
// the circular bit buffer, and runs the producer and consumer handshakes. A
// flush drains any residue as one final read word with its MSBs zero-padded.
//
// Ports:
//   clk, rst      clock (rising edge) and async active-high reset
//   wr_valid/rdy  producer handshake, WR_DATA_WIDTH bits per beat
//   rd_valid/rdy  consumer handshake, RD_DATA_WIDTH bits per beat
//   rd_last       current read beat is the final, padded drain beat
//   flush         request a drain of the residue (sampled only in RUN)
//   flush_done    one-cycle pulse after the drain completes
//   buf_wr_en/ptr write strobe and bit offset to the buffer datapath
//   buf_rd_en/ptr read strobe and bit offset to the buffer datapath
//   buf_rd_pad    number of read-word MSBs the datapath forces to zero
//   level         current occupancy in bits
module g2e_buffer_ctrl #(
  parameter int WR_DATA_WIDTH   = 8,
  parameter int RD_DATA_WIDTH   = 11,
  parameter int BUF_BUFFER_SIZE = 18,
  localparam int PW = $clog2(BUF_BUFFER_SIZE),
  localparam int LW = $clog2(BUF_BUFFER_SIZE + 1),
  localparam int QW = $clog2(RD_DATA_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  input  logic          flush,
  output logic          flush_done,
  output logic          buf_wr_en,
  output logic [PW-1:0] buf_wr_ptr,
  output logic          buf_rd_en,
  output logic [PW-1:0] buf_rd_ptr,
  output logic [QW-1:0] buf_rd_pad,
  output logic [LW-1:0] level
);

  // A write may only be accepted when a full read cannot be made, so the
  // buffer must hold that worst-case residue plus one write beat.
  if (BUF_BUFFER_SIZE < WR_DATA_WIDTH + RD_DATA_WIDTH - 1) begin : g_size_chk
    $error("g2e_buffer_ctrl: BUF_BUFFER_SIZE too small for WR/RD widths");
  end

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  localparam logic [LW:0]   L_WR  = (LW+1)'(WR_DATA_WIDTH);
  localparam logic [LW:0]   L_RD  = (LW+1)'(RD_DATA_WIDTH);
  localparam logic [LW:0]   L_SZ  = (LW+1)'(BUF_BUFFER_SIZE);
  localparam logic [PW:0]   P_WR  = (PW+1)'(WR_DATA_WIDTH);
  localparam logic [PW:0]   P_RD  = (PW+1)'(RD_DATA_WIDTH);
  localparam logic [PW:0]   P_SZ  = (PW+1)'(BUF_BUFFER_SIZE);
  localparam logic [LW-1:0] LV_RD = LW'(RD_DATA_WIDTH);

  state_t        r_state, w_state_nx;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nx, w_rd_ptr_nx;
  logic [LW-1:0] r_level, w_level_nx;
  logic          r_flush_done, w_flush_done_nx;
  logic          w_wr_fire, w_rd_fire;
  logic [PW:0]   w_wr_sum, w_rd_sum, w_wr_inc, w_rd_inc;
  logic [LW:0]   w_lvl_sum;

  // Handshake side: depends only on registered state.
  always_comb begin
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    buf_rd_pad = '0;
    case (r_state)
      S_RUN: begin
        wr_ready = ({1'b0, r_level} + L_WR) <= L_SZ;
        rd_valid = r_level >= LV_RD;
      end
      S_DRAIN: begin
        rd_valid = r_level != '0;
        rd_last  = r_level <= LV_RD;
        if (rd_last) buf_rd_pad = QW'(LV_RD - r_level);
      end
      default: ;
    endcase
  end

  // Strobes are suppressed while reset is held, even if the producer or
  // consumer keeps its side of the handshake high.
  assign w_wr_fire  = wr_valid & wr_ready & ~rst;
  assign w_rd_fire  = rd_valid & rd_ready & ~rst;

  assign buf_wr_en  = w_wr_fire;
  assign buf_wr_ptr = r_wr_ptr;
  assign buf_rd_en  = w_rd_fire;
  assign buf_rd_ptr = r_rd_ptr;
  assign level      = r_level;
  assign flush_done = r_flush_done;

  // Modular pointer advance: one conditional subtract is enough because a
  // single step never exceeds the buffer size.
  assign w_wr_sum = {1'b0, r_wr_ptr} + P_WR;
  assign w_rd_sum = {1'b0, r_rd_ptr} + P_RD;
  assign w_wr_inc = (w_wr_sum >= P_SZ) ? w_wr_sum - P_SZ : w_wr_sum;
  assign w_rd_inc = (w_rd_sum >= P_SZ) ? w_rd_sum - P_SZ : w_rd_sum;

  assign w_lvl_sum = {1'b0, r_level} + (w_wr_fire ? L_WR : '0)
                                     - (w_rd_fire ? L_RD : '0);

  always_comb begin
    w_state_nx      = r_state;
    w_wr_ptr_nx     = w_wr_fire ? w_wr_inc[PW-1:0] : r_wr_ptr;
    w_rd_ptr_nx     = w_rd_fire ? w_rd_inc[PW-1:0] : r_rd_ptr;
    w_level_nx      = w_lvl_sum[LW-1:0];
    w_flush_done_nx = 1'b0;
    case (r_state)
      S_RUN: begin
        if (flush) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_level == '0) begin
          w_state_nx      = S_RUN;
          w_flush_done_nx = 1'b1;
        end else if (w_rd_fire && rd_last) begin
          // The padded beat consumes the residue; the read pointer jumps to
          // the write pointer so the next word starts on fresh data.
          w_level_nx      = '0;
          w_rd_ptr_nx     = r_wr_ptr;
          w_state_nx      = S_RUN;
          w_flush_done_nx = 1'b1;
        end
      end
      default: w_state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_wr_ptr     <= w_wr_ptr_nx;
      r_rd_ptr     <= w_rd_ptr_nx;
      r_level      <= w_level_nx;
      r_flush_done <= w_flush_done_nx;
    end
  end

endmodule

// File: tb/tb_g2e_buffer_ctrl.sv
// Bench for g2e_buffer_ctrl: a directed vector table, hand-written reset and
// drain sequences, and a random stream. A bit-level buffer model stores every
// written beat at buf_wr_ptr; a scoreboard queue of written bits is popped on
// each read beat and compared with the word the model returns at buf_rd_ptr.
module tb_g2e_buffer_ctrl;
  localparam int WR = 8, RD = 11, SZ = 18;

  logic       clk, rst;
  logic       wr_valid, wr_ready, rd_valid, rd_ready, rd_last;
  logic       flush, flush_done, buf_wr_en, buf_rd_en;
  logic [4:0] buf_wr_ptr, buf_rd_ptr, level;
  logic [3:0] buf_rd_pad;
  logic [7:0] wdata;

  g2e_buffer_ctrl dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .flush(flush), .flush_done(flush_done), .buf_wr_en(buf_wr_en),
    .buf_wr_ptr(buf_wr_ptr), .buf_rd_en(buf_rd_en), .buf_rd_ptr(buf_rd_ptr),
    .buf_rd_pad(buf_rd_pad), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int n_wr_beats = 0, n_rd_beats = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Buffer datapath model and scoreboard.
  logic [SZ-1:0] mem;
  bit            sbq[$];
  logic [RD-1:0] m_act, m_exp;
  int            m_nv;

  always @(posedge clk)
    if (buf_wr_en)
      for (int i = 0; i < WR; i++) mem[(int'(buf_wr_ptr) + i) % SZ] <= wdata[i];

  always @(negedge clk) begin
    if (rst) sbq.delete();
    else begin
      chk("level_max", 32'(level <= 5'(SZ)), 32'd1);
      if (buf_rd_en) begin
        m_nv  = RD - int'(buf_rd_pad);
        m_act = '0;
        m_exp = '0;
        for (int i = 0; i < RD; i++)
          if (i < m_nv) m_act[i] = mem[(int'(buf_rd_ptr) + i) % SZ];
        for (int i = 0; i < m_nv; i++)
          if (sbq.size() > 0) m_exp[i] = sbq.pop_front();
          else chk("sb_underflow", 32'(sbq.size()), 32'd1);
        chk("rd_word", 32'(m_act), 32'(m_exp));
        n_rd_beats++;
      end
      if (buf_wr_en) begin
        for (int i = 0; i < WR; i++) sbq.push_back(wdata[i]);
        n_wr_beats++;
      end
    end
  end

  typedef struct {
    logic wv, rr, fl;
    logic e_wrdy, e_rv, e_last; int e_pad;
    logic e_wen; int e_wp;
    logic e_ren; int e_rp;
    int   e_lv; logic e_fd;
    logic ck_last;
  } vec_t;
  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc, w0, r0, l0, guard;
    bit fired, stalled;
    //           wv rr fl  wrdy rv last pad  wen wp  ren rp  lv fd  ck
    tbl[0]  = '{1, 0, 0,  1, 0, 0, 0,  1, 0,   0, 0,   0,  0, 1};
    tbl[1]  = '{1, 0, 0,  1, 0, 0, 0,  1, 8,   0, 0,   8,  0, 1};
    tbl[2]  = '{1, 0, 0,  0, 1, 0, 0,  0, 16,  0, 0,   16, 0, 1};
    tbl[3]  = '{1, 1, 0,  0, 1, 0, 0,  0, 16,  1, 0,   16, 0, 1};
    tbl[4]  = '{1, 1, 0,  1, 0, 0, 0,  1, 16,  0, 11,  5,  0, 1};
    tbl[5]  = '{0, 0, 1,  0, 1, 0, 0,  0, 6,   0, 11,  13, 0, 1};
    tbl[6]  = '{1, 1, 0,  0, 1, 0, 0,  0, 6,   1, 11,  13, 0, 1};
    tbl[7]  = '{1, 1, 0,  0, 1, 1, 9,  0, 6,   1, 4,   2,  0, 1};
    tbl[8]  = '{0, 0, 0,  1, 0, 0, 0,  0, 6,   0, 6,   0,  1, 1};
    tbl[9]  = '{0, 0, 1,  1, 0, 0, 0,  0, 6,   0, 6,   0,  0, 1};
    tbl[10] = '{1, 1, 0,  0, 0, 0, 0,  0, 6,   0, 6,   0,  0, 0};
    tbl[11] = '{0, 0, 0,  1, 0, 0, 0,  0, 6,   0, 6,   0,  1, 1};
    tbl[12] = '{1, 1, 0,  1, 0, 0, 0,  1, 6,   0, 6,   0,  0, 1};
    tbl[13] = '{1, 1, 0,  1, 0, 0, 0,  1, 14,  0, 6,   8,  0, 1};
    tbl[14] = '{0, 1, 0,  0, 1, 0, 0,  0, 4,   1, 6,   16, 0, 1};
    tbl[15] = '{1, 0, 0,  1, 0, 0, 0,  1, 4,   0, 17,  5,  0, 1};
    tbl[16] = '{0, 1, 0,  0, 1, 0, 0,  0, 12,  1, 17,  13, 0, 1};
    tbl[17] = '{0, 0, 0,  1, 0, 0, 0,  0, 12,  0, 10,  2,  0, 1};

    // Reset with both handshakes asserted: strobes must stay low.
    rst = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1; flush = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 1); chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);   chk("rst_pad", buf_rd_pad, 0);
    chk("rst_wr_en", buf_wr_en, 0);   chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_level", level, 0);       chk("rst_flush_done", flush_done, 0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      wr_valid = tbl[k].wv; rd_ready = tbl[k].rr; flush = tbl[k].fl;
      wdata = 8'($urandom);
      @(negedge clk);
      chk($sformatf("v%0d_wr_ready", k), wr_ready, tbl[k].e_wrdy);
      chk($sformatf("v%0d_rd_valid", k), rd_valid, tbl[k].e_rv);
      if (tbl[k].ck_last) begin
        chk($sformatf("v%0d_rd_last", k), rd_last, tbl[k].e_last);
        chk($sformatf("v%0d_rd_pad", k), buf_rd_pad, tbl[k].e_pad);
      end
      chk($sformatf("v%0d_wr_en", k), buf_wr_en, tbl[k].e_wen);
      chk($sformatf("v%0d_wr_ptr", k), buf_wr_ptr, tbl[k].e_wp);
      chk($sformatf("v%0d_rd_en", k), buf_rd_en, tbl[k].e_ren);
      chk($sformatf("v%0d_rd_ptr", k), buf_rd_ptr, tbl[k].e_rp);
      chk($sformatf("v%0d_level", k), level, tbl[k].e_lv);
      chk($sformatf("v%0d_flush_done", k), flush_done, tbl[k].e_fd);
      @(posedge clk); #1;
    end
    chk("sb_after_table", sbq.size(), level);

    // Reach DRAIN at level 7: 2 -> 10 -> 18 -> 7, then flush.
    wr_valid = 1'b1; rd_ready = 1'b0; flush = 1'b0;
    repeat (2) begin wdata = 8'($urandom); @(posedge clk); #1; end
    wr_valid = 1'b0; rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; wr_valid = 1'b1;
    @(negedge clk);
    chk("d7_level", level, 7);     chk("d7_rd_valid", rd_valid, 1);
    chk("d7_rd_last", rd_last, 1); chk("d7_pad", buf_rd_pad, 4);
    chk("d7_wr_ready", wr_ready, 0); chk("d7_rd_ptr", buf_rd_ptr, 3);
    // Async reset mid-cycle, with the consumer ready.
    rd_ready = 1'b1; #1 rst = 1'b1; #1;
    chk("ar_level", level, 0);       chk("ar_rd_valid", rd_valid, 0);
    chk("ar_rd_last", rd_last, 0);   chk("ar_pad", buf_rd_pad, 0);
    chk("ar_wr_ready", wr_ready, 1); chk("ar_rd_en", buf_rd_en, 0);
    chk("ar_wr_en", buf_wr_en, 0);   chk("ar_flush_done", flush_done, 0);
    repeat (2) begin @(posedge clk); #1; chk("ar_fd_hold", flush_done, 0); end
    rst = 1'b0; rd_ready = 1'b0; wdata = 8'($urandom);
    @(negedge clk);
    chk("post_rst_wr_en", buf_wr_en, 1); chk("post_rst_wr_ptr", buf_wr_ptr, 0);
    chk("post_rst_fd", flush_done, 0);
    @(posedge clk); #1;

    // Random stream; a write beat is held until accepted.
    w0 = n_wr_beats; r0 = n_rd_beats; l0 = int'(level);
    wait_cyc = 0; fired = 1'b1; stalled = 1'b0; wr_valid = 1'b0;
    for (int n = 0; n < 2000 && !stalled; n++) begin
      if (!wr_valid || fired) begin
        wr_valid = 1'($urandom_range(0, 1)); wdata = 8'($urandom); wait_cyc = 0;
      end else wait_cyc++;
      rd_ready = 1'($urandom_range(0, 1));
      if (wait_cyc > 100) begin
        chk("wr_stall_cycles", wait_cyc, 100); stalled = 1'b1;
      end
      @(negedge clk);
      fired = buf_wr_en;
      @(posedge clk); #1;
    end
    chk("conservation", (n_wr_beats - w0) * WR - (n_rd_beats - r0) * RD,
        int'(level) - l0);
    chk("sb_after_random", sbq.size(), level);

    // Final flush: drain residue, expect flush_done within a bounded window.
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; rd_ready = 1'b1; guard = 0;
    while (!flush_done && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("drain_done_seen", flush_done, 1);
    chk("drain_level", level, 0);
    chk("drain_wr_ready", wr_ready, 1);
    chk("drain_sb_empty", sbq.size(), 0);
    @(posedge clk); #1;
    chk("drain_fd_pulse", flush_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
